fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the issue stage.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs in a small FIFO and presents one instruction per cycle to issue.
- Supports a one-cycle redirect (branch/jump) that flushes buffered and in-flight fetches; drives a NOP whenever it has nothing valid.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries with a combinational head and synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!nrst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word requests,
// buffers in-order responses and presents one instruction (or NOP) to issue.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            nrst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 16;

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [DW-1:0]   drop_reg, drop_next;
  logic            run_reg;

  fetch_entry_t    fifo_head, fifo_push_data;
  fetch_entry_t    pend_head, pend_push_data;
  logic [CW-1:0]   fifo_count, pend_count;
  logic            fifo_empty, fifo_full, pend_empty, pend_full;
  logic            req_fire, rsp_keep, rsp_drop, fifo_pop;
  logic [CW:0]     in_use;
  logic            misc_unused;

  // Buffered plus in-flight fetches may never exceed the FIFO capacity.
  assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign imem_req_valid = run_reg && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_addr      = pc_reg;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_reg != '0);
  assign rsp_keep = imem_rsp_valid && (drop_reg == '0) && !redirect_valid;
  assign fifo_pop = inst_valid && !stall;

  always_comb begin
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg;
    drop_next        = drop_reg;
    if (redirect_valid) begin
      pc_next          = {redirect_pc[XLEN-1:2], 2'b00};
      outstanding_next = '0;
      drop_next        = drop_reg + DW'(outstanding_reg) - DW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_next = pc_reg + XLEN'(4);
      if (rsp_drop) drop_next = drop_reg - 1'b1;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      run_reg         <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      run_reg         <= 1'b1;
    end
  end

  // Requests whose responses will be dropped are flushed from the pending-PC
  // queue at redirect time, so it only ever holds PCs of responses to keep.
  assign pend_push_data = '{pc: pc_reg, inst: '0};

  fetch_fifo #(.DEPTH(DEPTH)) u_pend_q (
    .clk       (clk),
    .nrst      (nrst),
    .push      (req_fire),
    .push_data (pend_push_data),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head      (pend_head),
    .empty     (pend_empty),
    .full      (pend_full),
    .count     (pend_count)
  );

  assign fifo_push_data = '{pc: pend_head.pc, inst: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .nrst      (nrst),
    .push      (rsp_keep),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? fifo_head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? fifo_head.pc : '0;

  assign misc_unused = ^{pend_head.inst, pend_empty, pend_full, pend_count, fifo_full};

  rsp_expected_chk: assert property (@(posedge clk) disable iff (!nrst)
    imem_rsp_valid |-> ((outstanding_reg != '0) || (drop_reg != '0)));

  rsp_pc_known_chk: assert property (@(posedge clk) disable iff (!nrst)
    rsp_keep |-> !pend_empty);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an in-order memory model, a program-order
// reference of expected (pc, word) pairs, directed scenarios and a random soak.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  int           cyc = 0;
  int           since_rst = 0;
  int           checks = 0;
  int           failures = 0;
  int           consumed = 0;
  int           lat_min = 1;
  int           lat_max = 1;
  logic [31:0]  model_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9e37_79b9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!nrst) since_rst = 0;
    else since_rst++;
  end

  // Memory: in order, never back-pressured, per-request latency >= 1.
  always @(posedge clk) begin
    #1;
    if (!nrst) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Monitor and reference model: program order restarts at every redirect.
  always @(negedge clk) begin : monitor
    fetch_entry_t e;
    if (!nrst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (since_rst >= 1) begin
      chk("credit_req_valid", 32'(imem_req_valid),
          32'(!redirect_valid && (exp_q.size() < DEPTH)));
      if (imem_req_valid) chk("req_addr", imem_addr, model_pc);
      if (!inst_valid) begin
        chk("empty_inst_nop", inst, NOP_INST);
        chk("empty_inst_pc", inst_pc, 32'h0);
      end
      if (imem_req_valid && imem_req_ready) begin
        exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
        mem_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        model_pc = model_pc + 32'd4;
      end
      if (inst_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual_pc=0x%08h required=no_instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc", inst_pc, e.pc);
          chk("issue_inst", inst, e.inst);
          consumed++;
          $display("issue pc=0x%08h inst=0x%08h", inst_pc, inst);
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the caller just after the first clock edge with reset released (cycle 1).
  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    release_rst();
  endtask

  initial begin
    int found;
    int base;

    // Reset state
    #1 nrst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // Streaming, latency 1
    release_rst();
    sample();
    chk("t1_c1_inst_valid", 32'(inst_valid), 32'h0);
    chk("t1_c1_addr", imem_addr, RESET_PC);
    next_cycle(); sample();
    chk("t1_c2_inst_valid", 32'(inst_valid), 32'h0);
    next_cycle(); sample();
    chk("t1_c3_inst_valid", 32'(inst_valid), 32'h1);
    chk("t1_c3_inst_pc", inst_pc, RESET_PC);
    repeat (20) next_cycle();

    // Stall for 5 cycles: credit fills, head held
    stall = 1'b1;
    do_reset();
    repeat (4) next_cycle();
    sample();
    chk("t2_full_req_valid", 32'(imem_req_valid), 32'h0);
    chk("t2_head_valid", 32'(inst_valid), 32'h1);
    chk("t2_head_pc", inst_pc, RESET_PC);
    next_cycle();
    stall = 1'b0;
    repeat (10) next_cycle();

    // Memory not ready for 3 cycles while requesting 0x8
    do_reset();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_addr == 32'h8) begin
        found = 1;
        break;
      end
      next_cycle();
    end
    chk("t3_found_addr8", 32'(found), 32'h1);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t3_req_valid_held", 32'(imem_req_valid), 32'h1);
      chk("t3_addr_held", imem_addr, 32'h8);
      next_cycle();
    end
    imem_req_ready = 1'b1;
    repeat (10) next_cycle();

    // Redirect to 0x103 with two responses in flight, latency 3
    lat_min = 3; lat_max = 3;
    do_reset();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    sample();
    chk("t4_redirect_no_req", 32'(imem_req_valid), 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("t4_new_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t4_new_addr", imem_addr, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle(); sample();
      if (inst_valid) begin
        found = 1;
        break;
      end
    end
    chk("t4_first_seen", 32'(found), 32'h1);
    chk("t4_first_pc", inst_pc, 32'h0000_0100);
    repeat (10) next_cycle();
    lat_min = 1; lat_max = 1;

    // Redirect coinciding with a response and a stall
    stall = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    sample();
    chk("t5_pre_inst_valid", 32'(inst_valid), 32'h1);
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    chk("t5_flushed_valid", 32'(inst_valid), 32'h0);
    chk("t5_flushed_inst", inst, NOP_INST);
    chk("t5_flushed_pc", inst_pc, 32'h0);
    chk("t5_new_addr", imem_addr, 32'h0000_0200);
    next_cycle();
    stall = 1'b0;
    repeat (10) next_cycle();

    // Reset mid-stream with the FIFO full
    stall = 1'b1;
    do_reset();
    repeat (4) next_cycle();
    sample();
    chk("t6_pre_full_valid", 32'(inst_valid), 32'h1);
    chk("t6_pre_full_req", 32'(imem_req_valid), 32'h0);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    chk("t6_rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("t6_rst_inst", inst, NOP_INST);
    stall = 1'b0;
    release_rst();
    sample();
    chk("t6_restart_req", 32'(imem_req_valid), 32'h1);
    chk("t6_restart_addr", imem_addr, RESET_PC);
    repeat (10) next_cycle();

    // Random soak: ready, stall, redirects (incl. near the top of the address space)
    lat_min = 1; lat_max = 4;
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                   : $urandom;
    end
    next_cycle();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    repeat (20) next_cycle();
    chk("random_progress", 32'((consumed - base) > 200), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
